// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: syncs, active/border flags, counters, fb row index
// Optional raster line interrupt: define VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 11,
    parameter int H_SYNC     = 56,
    parameter int H_BP       = 29,
    parameter int V_ACTIVE   = 584,
    parameter int V_FP       = 25,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 19,
    parameter int FB_TOP     = 32,
    parameter int FB_LINES   = 512,
    parameter int ROW_REPEAT = 2,
    parameter int FB_LEFT    = 64,
    parameter int FB_WIDTH   = 512,
    parameter int SYNC_POL   = 0
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        ce,
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    input  logic [9:0]  irq_line,
    input  logic        irq_ack,
`endif
    input  logic [7:0]  scroll_reg,
    output logic        hsync,
    output logic        vsync,
    output logic        video_active,
    output logic        retrace,
    output logic        border,
    output logic [10:0] xpos,
    output logic [9:0]  ypos,
    output logic [7:0]  fb_row,
    output logic        line_start,
    output logic        frame_start,
    output logic        irq
);
    typedef enum logic [1:0] {PH_FP, PH_SYNC, PH_BP, PH_ACT} phase_t;

    localparam logic [10:0] H_FP_M1   = 11'(H_FP - 1);
    localparam logic [10:0] H_SYNC_M1 = 11'(H_SYNC - 1);
    localparam logic [10:0] H_BP_M1   = 11'(H_BP - 1);
    localparam logic [10:0] H_ACT_M1  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_FP_M1   = 10'(V_FP - 1);
    localparam logic [9:0]  V_SYNC_M1 = 10'(V_SYNC - 1);
    localparam logic [9:0]  V_BP_M1   = 10'(V_BP - 1);
    localparam logic [9:0]  V_ACT_M1  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  Y_TOP     = 10'(FB_TOP);
    localparam logic [10:0] Y_END     = 11'(FB_TOP + FB_LINES);
    localparam logic [10:0] X_LEFT    = 11'(FB_LEFT);
    localparam logic [11:0] X_END     = 12'(FB_LEFT + FB_WIDTH);
    localparam logic        REP_LAST  = (ROW_REPEAT == 2);
    localparam logic        SYNC_ON   = (SYNC_POL != 0);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        H_ACTIVE > 2048 || H_FP > 2048 || H_SYNC > 2048 || H_BP > 2048 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        V_ACTIVE > 1024 || V_FP > 1024 || V_SYNC > 1024 || V_BP > 1024 ||
        FB_LINES < 1 || FB_WIDTH < 1 || FB_TOP < 0 || FB_LEFT < 0 ||
        FB_TOP + FB_LINES > V_ACTIVE || FB_LEFT + FB_WIDTH > H_ACTIVE ||
        ROW_REPEAT < 1 || ROW_REPEAT > 2) begin : g_bad_params
        $fatal(1, "video_timing_gen: illegal parameter set");
    end

    phase_t      r_h_state, r_v_state;
    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_rep;
    logic        r_hsync, r_vsync, r_video_active, r_retrace, r_border;
    logic        r_line_start, r_frame_start;
    logic [10:0] r_xpos;
    logic [9:0]  r_ypos;
    logic [7:0]  r_fb_row;

    phase_t      w_h_state_nx, w_v_state_nx;
    logic [10:0] w_h_last, w_h_cnt_nx, w_xpos_nx;
    logic [9:0]  w_v_last, w_v_cnt_nx, w_ypos_nx;
    logic        w_h_wrap, w_v_wrap, w_line_adv, w_hact, w_vact, w_act_start;
    logic        w_x_border, w_y_border, w_rep_nx;
    logic [7:0]  w_fb_row_nx;

    always_comb begin
        case (r_h_state)
            PH_FP:   w_h_last = H_FP_M1;
            PH_SYNC: w_h_last = H_SYNC_M1;
            PH_BP:   w_h_last = H_BP_M1;
            default: w_h_last = H_ACT_M1;
        endcase
        w_h_wrap     = (r_h_cnt == w_h_last);
        w_h_state_nx = r_h_state;
        w_h_cnt_nx   = r_h_cnt + 11'd1;
        if (w_h_wrap) begin
            w_h_cnt_nx = '0;
            case (r_h_state)
                PH_FP:   w_h_state_nx = PH_SYNC;
                PH_SYNC: w_h_state_nx = PH_BP;
                PH_BP:   w_h_state_nx = PH_ACT;
                default: w_h_state_nx = PH_FP;
            endcase
        end
        // The vertical FSM steps once per line, on the tick that enters H front porch
        w_line_adv = w_h_wrap && (r_h_state == PH_ACT);

        case (r_v_state)
            PH_FP:   w_v_last = V_FP_M1;
            PH_SYNC: w_v_last = V_SYNC_M1;
            PH_BP:   w_v_last = V_BP_M1;
            default: w_v_last = V_ACT_M1;
        endcase
        w_v_wrap     = (r_v_cnt == w_v_last);
        w_v_state_nx = r_v_state;
        w_v_cnt_nx   = r_v_cnt;
        if (w_line_adv) begin
            if (w_v_wrap) begin
                w_v_cnt_nx = '0;
                case (r_v_state)
                    PH_FP:   w_v_state_nx = PH_SYNC;
                    PH_SYNC: w_v_state_nx = PH_BP;
                    PH_BP:   w_v_state_nx = PH_ACT;
                    default: w_v_state_nx = PH_FP;
                endcase
            end else begin
                w_v_cnt_nx = r_v_cnt + 10'd1;
            end
        end

        w_hact      = (w_h_state_nx == PH_ACT);
        w_vact      = (w_v_state_nx == PH_ACT);
        w_xpos_nx   = w_hact ? w_h_cnt_nx : '0;
        w_ypos_nx   = w_vact ? w_v_cnt_nx : '0;
        w_act_start = w_h_wrap && (r_h_state == PH_BP) && w_vact;
        w_x_border  = (w_xpos_nx < X_LEFT) || ({1'b0, w_xpos_nx} >= X_END);
        w_y_border  = (w_ypos_nx < Y_TOP) || ({1'b0, w_ypos_nx} >= Y_END);

        // Row index loads at the window's first line, then steps down every ROW_REPEAT lines
        w_fb_row_nx = r_fb_row;
        w_rep_nx    = r_rep;
        if (w_act_start) begin
            if (w_ypos_nx == Y_TOP) begin
                w_fb_row_nx = scroll_reg;
                w_rep_nx    = 1'b0;
            end else if (w_ypos_nx > Y_TOP && {1'b0, w_ypos_nx} < Y_END) begin
                if (r_rep == REP_LAST) begin
                    w_fb_row_nx = r_fb_row - 8'd1;
                    w_rep_nx    = 1'b0;
                end else begin
                    w_rep_nx    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (reset) begin
            r_h_state      <= PH_FP;
            r_v_state      <= PH_FP;
            r_h_cnt        <= '0;
            r_v_cnt        <= '0;
            r_rep          <= 1'b0;
            r_hsync        <= ~SYNC_ON;
            r_vsync        <= ~SYNC_ON;
            r_video_active <= 1'b0;
            r_retrace      <= 1'b0;
            r_border       <= 1'b0;
            r_xpos         <= '0;
            r_ypos         <= '0;
            r_fb_row       <= 8'hFF;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
        end else if (ce) begin
            r_h_state      <= w_h_state_nx;
            r_v_state      <= w_v_state_nx;
            r_h_cnt        <= w_h_cnt_nx;
            r_v_cnt        <= w_v_cnt_nx;
            r_rep          <= w_rep_nx;
            r_hsync        <= (w_h_state_nx == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
            r_vsync        <= (w_v_state_nx == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
            r_video_active <= w_hact && w_vact;
            r_retrace      <= !w_vact;
            r_border       <= w_hact && w_vact && (w_x_border || w_y_border);
            r_xpos         <= w_xpos_nx;
            r_ypos         <= w_ypos_nx;
            r_fb_row       <= w_fb_row_nx;
            r_line_start   <= w_act_start;
            r_frame_start  <= w_act_start && (w_ypos_nx == '0);
        end
    end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic r_irq;
    // A set on the same clock as an ack wins so the interrupt is never lost
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (ce && w_act_start && (w_ypos_nx == irq_line)) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign video_active = r_video_active;
    assign retrace      = r_retrace;
    assign border       = r_border;
    assign xpos         = r_xpos;
    assign ypos         = r_ypos;
    assign fb_row       = r_fb_row;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - random-ce bench for video_timing_gen against a tick-count raster model
module tb_video_timing_gen;
    localparam int HA = 40, HF = 3, HS = 4, HB = 5;
    localparam int VA = 30, VF = 2, VS = 2, VB = 4;
    localparam int FT = 4, FL = 20, RR = 2, FLF = 6, FW = 24;
    localparam int HAS = HF + HS + HB;
    localparam int LT  = HAS + HA;
    localparam int VAS = VF + VS + VB;
    localparam int FR  = VAS + VA;
    localparam int FTK = FR * LT;

    logic        clk24 = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [7:0]  scroll_reg = 8'h00;
    logic        hsync, vsync, video_active, retrace, border, line_start, frame_start, irq;
    logic [10:0] xpos;
    logic [9:0]  ypos;
    logic [7:0]  fb_row;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic [9:0]  irq_line = 10'd10;
    logic        irq_ack = 1'b0;
    int          m_irq = 0;
`endif

    int     n_cmp = 0, n_bad = 0;
    longint t = 0;
    longint fs_t = -1;
    int     m_fb = 255;
    bit     chk_en = 0;
    int     phase = 0;
    int     hs_low = 0, vs_low = 0;

    always #5 clk24 = ~clk24;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_TOP(FT), .FB_LINES(FL), .ROW_REPEAT(RR),
        .FB_LEFT(FLF), .FB_WIDTH(FW), .SYNC_POL(0)
    ) dut (
        .clk24(clk24), .reset(reset), .ce(ce),
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        .irq_line(irq_line), .irq_ack(irq_ack),
`endif
        .scroll_reg(scroll_reg),
        .hsync(hsync), .vsync(vsync), .video_active(video_active), .retrace(retrace),
        .border(border), .xpos(xpos), .ypos(ypos), .fb_row(fb_row),
        .line_start(line_start), .frame_start(frame_start), .irq(irq)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, t);
        end
    endtask

    task automatic compare();
        int hp, ln, x, y;
        bit r0, hact, vact, va, bd, ls;
        hp   = int'(t % LT);
        ln   = int'((t / LT) % FR);
        r0   = (t == 0);
        hact = !r0 && hp >= HAS;
        vact = !r0 && ln >= VAS;
        va   = hact && vact;
        x    = hact ? hp - HAS : 0;
        y    = vact ? ln - VAS : 0;
        bd   = va && (y < FT || y >= FT + FL || x < FLF || x >= FLF + FW);
        ls   = va && hp == HAS;
        chk("hsync", hsync, !(!r0 && hp >= HF && hp < HF + HS));
        chk("vsync", vsync, !(!r0 && ln >= VF && ln < VF + VS));
        chk("video_active", video_active, va);
        chk("retrace", retrace, !r0 && ln < VAS);
        chk("border", border, bd);
        chk("xpos", xpos, x);
        chk("ypos", ypos, y);
        chk("fb_row", fb_row, m_fb);
        chk("line_start", line_start, ls);
        chk("frame_start", frame_start, ls && y == 0);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        chk("irq", irq, m_irq);
`else
        chk("irq", irq, 0);
`endif
        if (r0) begin
            chk("lit_rst_hsync", hsync, 1);
            chk("lit_rst_vsync", vsync, 1);
            chk("lit_rst_fb_row", fb_row, 8'hFF);
            chk("lit_rst_xpos", xpos, 0);
            chk("lit_rst_ypos", ypos, 0);
            chk("lit_rst_active", video_active, 0);
        end
        if (frame_start && fs_t < 0) fs_t = t;
        if (phase == 2) begin
            if (t >= 1 && t <= FTK) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
            end
            if (va && x == 0 && t < FTK) begin
                case (y)
                    4, 5:   chk("lit_fb_load", fb_row, 8'h10);
                    6:      chk("lit_fb_step", fb_row, 8'h0F);
                    23, 27: chk("lit_fb_hold", fb_row, 8'h07);
                    default: ;
                endcase
            end
            if (va && x == 0 && t >= FTK && t < 2 * FTK) begin
                case (y)
                    8:  chk("lit_fb_zero", fb_row, 8'h00);
                    10: chk("lit_fb_wrap", fb_row, 8'hFF);
                    default: ;
                endcase
            end
            if (va && t < FTK) begin
                if (x == 5 && y == 10)  chk("lit_border_left", border, 1);
                if (x == 6 && y == 4)   chk("lit_border_corner", border, 0);
                if (x == 30 && y == 10) chk("lit_border_right", border, 1);
                if (x == 10 && y == 3)  chk("lit_border_top", border, 1);
                if (x == 29 && y == 23) chk("lit_border_inner", border, 0);
                if (x == 10 && y == 24) chk("lit_border_bottom", border, 1);
            end
        end
    endtask

    task automatic model_update();
        int hp, ln, k;
        if (reset) begin
            t      = 0;
            m_fb   = 255;
            chk_en = 1;
            fs_t   = -1;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
            m_irq  = 0;
`endif
        end else begin
            hp = -1;
            ln = -1;
            if (ce) begin
                t++;
                hp = int'(t % LT);
                ln = int'((t / LT) % FR);
                if (hp == HAS && ln >= VAS) begin
                    k = ln - VAS - FT;
                    if (k == 0) m_fb = int'(scroll_reg);
                    else if (k > 0 && k < FL && k % RR == 0) m_fb = (m_fb + 255) % 256;
                end
            end
`ifdef VIDEO_TIMING_LINE_IRQ_EN
            if (ce && hp == HAS && ln >= VAS && ln - VAS == int'(irq_line)) m_irq = 1;
            else if (irq_ack) m_irq = 0;
`endif
        end
    endtask

    task automatic cycle(input bit rst, input bit c, input logic [7:0] scr);
        @(negedge clk24);
        if (chk_en) compare();
        reset      = rst;
        ce         = c;
        scroll_reg = scr;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        irq_ack    = ($urandom_range(0, 15) == 0);
`endif
        model_update();
    endtask

    initial begin
        bit did_rst;
        bit r;
        phase = 1;
        repeat (3) cycle(1'b1, 1'b1, 8'h00);

        phase = 2;
        for (int i = 0; i < 2 * FTK + 30; i++)
            cycle(1'b0, 1'b1, (t < FTK) ? 8'h10 : 8'h02);
        chk("lit_hsync_low_ticks", hs_low, FR * HS);
        chk("lit_vsync_low_ticks", vs_low, VS * LT);
        chk("lit_first_frame_start", fs_t, VAS * LT + HAS);

        phase = 3;
        for (int i = 0; i < 1200; i++)
            cycle(1'b0, (i % 2) == 0, 8'($urandom));

        phase = 4;
        did_rst = 0;
        for (int i = 0; i < 9000; i++) begin
            r = !did_rst && ((t / LT) % FR == VAS + 15) && (t % LT > HAS + 5);
            if (r) did_rst = 1;
            cycle(r, r ? 1'b1 : ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        chk("lit_reset_occurred", did_rst, 1);
        chk("lit_frame_start_after_reset", fs_t, VAS * LT + HAS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
